// File: rtl/even_parity_chk_if.sv
// Bus bundle for the serial even-parity checker: serial bit input plus the
// recovered word, status flags and error counter.
interface even_parity_chk_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) ();
    // Handshake: the receiver is always ready, so there is no ready signal.
    // A bit on i_x is consumed on every rising clk edge where i_valid is high,
    // and i_clear in the same cycle overrides and discards that bit.
    logic              i_x;
    logic              i_valid;
    logic              i_clear;
    logic [DATA_W-1:0] o_data;
    logic              o_done;
    logic              o_par_err;
    logic              o_parity;
    logic              o_busy;
    logic [CNT_W-1:0]  o_err_cnt;

    modport master (
        output i_x, i_valid, i_clear,
        input  o_data, o_done, o_par_err, o_parity, o_busy, o_err_cnt
    );

    modport slave (
        input  i_x, i_valid, i_clear,
        output o_data, o_done, o_par_err, o_parity, o_busy, o_err_cnt
    );
endinterface

// File: rtl/even_parity_chk.sv
// Serial even-parity checker: deserialises DATA_W data bits (LSB first) plus a
// parity bit, flags odd-parity frames and counts them in a saturating counter.
module even_parity_chk #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    even_parity_chk_if.slave  bus,
    output logic [1:0]        state_dbg
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0]    LAST    = CW'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic [DATA_W-1:0] data_n;
    logic              parity_n;
    logic              par_err_n;
    logic              done_n;
    logic              busy_n;
    logic [CNT_W-1:0]  err_cnt_n;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            bus.o_data    <= '0;
            bus.o_done    <= 1'b0;
            bus.o_par_err <= 1'b0;
            bus.o_parity  <= 1'b0;
            bus.o_busy    <= 1'b0;
            bus.o_err_cnt <= '0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            shift         <= shift_n;
            bus.o_data    <= data_n;
            bus.o_done    <= done_n;
            bus.o_par_err <= par_err_n;
            bus.o_parity  <= parity_n;
            bus.o_busy    <= busy_n;
            bus.o_err_cnt <= err_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        data_n    = bus.o_data;
        par_err_n = bus.o_par_err;
        parity_n  = bus.o_parity;
        err_cnt_n = bus.o_err_cnt;
        done_n    = 1'b0;

        if (bus.i_clear) begin
            // Abort wins over a simultaneous valid bit; results and counter keep.
            state_n   = IDLE;
            bit_cnt_n = '0;
            shift_n   = '0;
            parity_n  = 1'b0;
        end else if (bus.i_valid) begin
            unique case (state)
                IDLE: begin
                    shift_n    = '0;
                    shift_n[0] = bus.i_x;
                    parity_n   = bus.i_x;
                    bit_cnt_n  = CW'(1);
                    state_n    = DATA;
                end
                DATA: begin
                    shift_n[bit_cnt] = bus.i_x;
                    parity_n         = bus.o_parity ^ bus.i_x;
                    if (bit_cnt == LAST) begin
                        bit_cnt_n = '0;
                        state_n   = PAR;
                    end else begin
                        bit_cnt_n = bit_cnt + CW'(1);
                    end
                end
                PAR: begin
                    data_n    = shift;
                    par_err_n = bus.o_parity ^ bus.i_x;
                    done_n    = 1'b1;
                    if (par_err_n && (bus.o_err_cnt != CNT_MAX)) begin
                        err_cnt_n = bus.o_err_cnt + CNT_W'(1);
                    end
                    parity_n  = 1'b0;
                    bit_cnt_n = '0;
                    state_n   = IDLE;
                end
                default: begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                    parity_n  = 1'b0;
                end
            endcase
        end

        busy_n = (state_n != IDLE);
    end
endmodule

// File: tb/tb_even_parity_chk.sv
// Self-checking bench for even_parity_chk: table-driven frames, clear/reset
// corner sequences and a long back-to-back run into counter saturation.
module tb_even_parity_chk;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int EW     = DATA_W + 1 + CNT_W;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              p;
        int                gap;
        logic              exp_perr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0] state_dbg;
    even_parity_chk_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    even_parity_chk #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int done_count = 0;
    int model_cnt  = 0;
    logic [EW-1:0] exp_q[$];
    int            stamp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic          prev_done = 1'b0;
    logic [EW-1:0] mon_e;
    int            mon_s;
    always @(negedge clk) begin
        if (!reset && bus.o_done) begin
            done_count++;
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_s = stamp_q.pop_front();
                check("data",    32'(bus.o_data),    32'(mon_e[EW-1 -: DATA_W]));
                check("par_err", 32'(bus.o_par_err), 32'(mon_e[CNT_W]));
                check("err_cnt", 32'(bus.o_err_cnt), 32'(mon_e[CNT_W-1:0]));
                check("latency", 32'(cyc - mon_s),   32'd1);
            end
        end
        prev_done = bus.o_done;
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input int gap,
                              input logic exp_perr, output logic busy_ok);
        busy_ok = 1'b1;
        for (int i = 0; i <= DATA_W; i++) begin
            @(negedge clk);
            bus.i_x     = (i == DATA_W) ? p : d[i];
            bus.i_valid = 1'b1;
            if (i == DATA_W) begin
                check("run_parity", 32'(bus.o_parity), 32'(^d));
                if (exp_perr && model_cnt < CNT_SAT) model_cnt++;
                exp_q.push_back({d, exp_perr, CNT_W'(model_cnt)});
                stamp_q.push_back(cyc);
            end
            for (int g = 0; g < gap && i < DATA_W; g++) begin
                @(negedge clk);
                bus.i_valid = 1'b0;
                if (!bus.o_busy) busy_ok = 1'b0;
            end
        end
    endtask

    task automatic drain();
        @(negedge clk);
        bus.i_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},    32'(bus.o_data),    32'd0);
        check({tag, "_done"},    32'(bus.o_done),    32'd0);
        check({tag, "_par_err"}, 32'(bus.o_par_err), 32'd0);
        check({tag, "_parity"},  32'(bus.o_parity),  32'd0);
        check({tag, "_busy"},    32'(bus.o_busy),    32'd0);
        check({tag, "_err_cnt"}, 32'(bus.o_err_cnt), 32'd0);
        check({tag, "_state"},   32'(state_dbg),     32'd0);
    endtask

    // ---------------- test ----------------
    vec_t vecs[6];
    logic busy_ok;
    logic [DATA_W-1:0] last_data;
    int dc0;

    initial begin
        vecs[0] = '{data: 8'hA5, p: 1'b0, gap: 0, exp_perr: 1'b0};
        vecs[1] = '{data: 8'h07, p: 1'b0, gap: 0, exp_perr: 1'b1};
        vecs[2] = '{data: 8'h07, p: 1'b1, gap: 0, exp_perr: 1'b0};
        vecs[3] = '{data: 8'h3C, p: 1'b0, gap: 3, exp_perr: 1'b0};
        for (int v = 4; v < 6; v++) begin
            vecs[v].data     = DATA_W'($urandom_range(0, 255));
            vecs[v].p        = 1'($urandom_range(0, 1));
            vecs[v].gap      = $urandom_range(0, 2);
            vecs[v].exp_perr = (^vecs[v].data) ^ vecs[v].p;
        end

        bus.i_x = 1'b0; bus.i_valid = 1'b0; bus.i_clear = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset");

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].data, vecs[v].p, vecs[v].gap, vecs[v].exp_perr, busy_ok);
            if (vecs[v].gap > 0) check("busy_in_gaps", 32'(busy_ok), 32'd1);
            drain();
            check("busy_idle", 32'(bus.o_busy), 32'd0);
            last_data = vecs[v].data;
        end

        // Clear with a simultaneous valid bit after 4 bits of 0xFF.
        dc0 = done_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) check("clr_parity_3bits", 32'(bus.o_parity), 32'd1);
            bus.i_x = 1'b1; bus.i_valid = 1'b1;
        end
        @(negedge clk);
        check("clr_parity_4bits", 32'(bus.o_parity), 32'd0);
        check("clr_busy_before",  32'(bus.o_busy),   32'd1);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0; bus.i_valid = 1'b0;
        check("clr_parity",  32'(bus.o_parity), 32'd0);
        check("clr_busy",    32'(bus.o_busy),   32'd0);
        check("clr_state",   32'(state_dbg),    32'd0);
        check("clr_data",    32'(bus.o_data),   32'(last_data));
        repeat (3) @(negedge clk);
        check("clr_no_done", 32'(done_count - dc0), 32'd0);
        send_frame(8'h81, 1'b0, 0, 1'b0, busy_ok);
        drain();

        // Reset in the middle of a frame.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.i_x = 1'b1; bus.i_valid = 1'b1;
        end
        @(negedge clk);
        reset = 1'b1; bus.i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        check_reset_outputs("midreset");
        send_frame(8'h01, 1'b1, 0, 1'b0, busy_ok);
        drain();

        // Back-to-back bad frames into counter saturation.
        dc0 = done_count;
        for (int f = 0; f < 300; f++) send_frame(8'h01, 1'b0, 0, 1'b1, busy_ok);
        drain();
        check("sat_done_count", 32'(done_count - dc0), 32'd300);
        check("sat_err_cnt",    32'(bus.o_err_cnt),    32'(CNT_SAT));
        check("queue_empty",    32'(exp_q.size()),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
